// File: rtl/photon_deadlock_pkg.sv
// Shared types for the photon trigger deadlock watchdog: FSM states, event
// counter width and the report record layout.
package photon_deadlock_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WATCH,
        REPORT,
        LATCHED
    } state_t;

    localparam int EVT_W     = 8;

    // Record fields are sized for the largest supported configuration; the
    // top slices out the bits its parameters actually use.
    localparam int REC_IDX_W = 5;
    localparam int REC_MON_W = 32;
    localparam int REC_CNT_W = 32;

    typedef struct packed {
        logic [REC_IDX_W-1:0] mon_idx;
        logic [REC_MON_W-1:0] mask;
        logic [REC_CNT_W-1:0] cycles;
    } report_t;

endpackage

// File: rtl/photon_lowest_set_idx.sv
// Priority encoder: index of the lowest set bit of a mask, plus an any-set flag.
module photon_lowest_set_idx
    import photon_deadlock_pkg::*;
#(
    parameter int W     = 4,
    parameter int IDX_W = 2
) (
    input  logic [W-1:0]     i_mask,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_any
);

    always_comb begin
        o_idx = '0;
        o_any = 1'b0;
        for (int unsigned i = 0; i < W; i++) begin
            if (i_mask[i] && !o_any) begin
                o_idx = IDX_W'(i);
                o_any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/photon_deadlock_watchdog.sv
// Qualifies HLS monitor block flags against ap_idle and a persistence timeout,
// raises a sticky deadlock flag and emits one report per event.
// Optional macro PHOTON_DEADLOCK_AUTO_REARM_EN: handshake re-arms directly, no clear needed.
module photon_deadlock_watchdog
    import photon_deadlock_pkg::*;
#(
    parameter int NUM_MON = 4,
    parameter int TIMEOUT = 1024,
    parameter int CNT_W   = 16,
    parameter int IDX_W   = (NUM_MON > 1) ? $clog2(NUM_MON) : 1
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [NUM_MON-1:0] block_in,
    input  logic               ap_idle,
    input  logic               clear,
    output logic               report_valid,
    input  logic               report_ready,
    output logic [IDX_W-1:0]   report_mon_idx,
    output logic [NUM_MON-1:0] report_mask,
    output logic [CNT_W-1:0]   report_cycles,
    output logic               deadlock,
    output logic [EVT_W-1:0]   event_count
);

    state_t             r_state;
    logic [CNT_W-1:0]   r_stall_cnt;
    logic [NUM_MON-1:0] r_acc_mask;
    report_t            r_rec;
    logic               r_valid;
    logic               r_deadlock;
    logic [EVT_W-1:0]   r_evt;

    logic               w_blk;
    logic [NUM_MON-1:0] w_new_mask;
    logic [IDX_W-1:0]   w_enc_idx;
    logic               w_enc_any;
    logic               w_unused_bits;

    assign w_blk      = (|block_in) & ~ap_idle;
    assign w_new_mask = r_acc_mask | block_in;

    photon_lowest_set_idx #(
        .W     (NUM_MON),
        .IDX_W (IDX_W)
    ) u_lowest (
        .i_mask (w_new_mask),
        .o_idx  (w_enc_idx),
        .o_any  (w_enc_any)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= IDLE;
            r_stall_cnt <= '0;
            r_acc_mask  <= '0;
            r_rec       <= '0;
            r_valid     <= 1'b0;
            r_deadlock  <= 1'b0;
            r_evt       <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_blk) begin
                        r_state     <= WATCH;
                        r_stall_cnt <= CNT_W'(1);
                        r_acc_mask  <= block_in;
                    end
                end
                WATCH: begin
                    if (!w_blk) begin
                        r_state     <= IDLE;
                        r_stall_cnt <= '0;
                        r_acc_mask  <= '0;
                    end else if (r_stall_cnt == CNT_W'(TIMEOUT - 1)) begin
                        r_state        <= REPORT;
                        r_rec.mon_idx  <= REC_IDX_W'(w_enc_idx);
                        r_rec.mask     <= REC_MON_W'(w_new_mask);
                        r_rec.cycles   <= REC_CNT_W'(TIMEOUT);
                        r_valid        <= 1'b1;
                        r_deadlock     <= 1'b1;
                        if (r_evt != '1) begin
                            r_evt <= r_evt + EVT_W'(1);
                        end
                    end else begin
                        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
                        r_acc_mask  <= w_new_mask;
                    end
                end
                REPORT: begin
                    if (report_ready) begin
                        r_valid <= 1'b0;
`ifdef PHOTON_DEADLOCK_AUTO_REARM_EN
                        r_state     <= IDLE;
                        r_deadlock  <= 1'b0;
                        r_stall_cnt <= '0;
                        r_acc_mask  <= '0;
`else
                        r_state <= LATCHED;
`endif
                    end
                end
                LATCHED: begin
`ifdef PHOTON_DEADLOCK_AUTO_REARM_EN
                    r_state <= IDLE;
`else
                    if (clear) begin
                        r_state     <= IDLE;
                        r_deadlock  <= 1'b0;
                        r_stall_cnt <= '0;
                        r_acc_mask  <= '0;
                    end
`endif
                end
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef PHOTON_DEADLOCK_AUTO_REARM_EN
    assign w_unused_bits = (^r_rec) ^ w_enc_any ^ clear;
`else
    assign w_unused_bits = (^r_rec) ^ w_enc_any;
`endif

    assign report_valid   = r_valid;
    assign report_mon_idx = r_rec.mon_idx[IDX_W-1:0];
    assign report_mask    = r_rec.mask[NUM_MON-1:0];
    assign report_cycles  = r_rec.cycles[CNT_W-1:0];
    assign deadlock       = r_deadlock;
    assign event_count    = r_evt;

endmodule

// File: tb/tb_photon_deadlock_watchdog.sv
// Scoreboard bench for photon_deadlock_watchdog (NUM_MON=4, TIMEOUT=8, CNT_W=16).
module tb_photon_deadlock_watchdog;

`ifdef PHOTON_DEADLOCK_AUTO_REARM_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset;
    logic [3:0]  block_in;
    logic        ap_idle;
    logic        clear;
    logic        report_valid;
    logic        report_ready;
    logic [1:0]  report_mon_idx;
    logic [3:0]  report_mask;
    logic [15:0] report_cycles;
    logic        deadlock;
    logic [7:0]  event_count;

    photon_deadlock_watchdog #(
        .NUM_MON (4),
        .TIMEOUT (8),
        .CNT_W   (16)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .block_in       (block_in),
        .ap_idle        (ap_idle),
        .clear          (clear),
        .report_valid   (report_valid),
        .report_ready   (report_ready),
        .report_mon_idx (report_mon_idx),
        .report_mask    (report_mask),
        .report_cycles  (report_cycles),
        .deadlock       (deadlock),
        .event_count    (event_count)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [3:0]  mask;
        logic [1:0]  idx;
        logic [15:0] cycles;
        logic [7:0]  evt;
        int          at;
    } exp_t;

    exp_t q[$];
    exp_t cur;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   exp_evt = 0;
    bit   prev_v = 1'b0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic expect_report(input logic [3:0] mask, input logic [1:0] idx, input int at);
        exp_t e;
        if (exp_evt < 255) exp_evt++;
        e.mask = mask; e.idx = idx; e.cycles = 16'd8; e.evt = 8'(exp_evt); e.at = at;
        q.push_back(e);
    endtask

    task automatic handshake_and_clear;
        report_ready = 1'b1;
        tick(1);
        report_ready = 1'b0;
        block_in = 4'b0000;
        cmp("post_hs_valid", {31'd0, report_valid}, 32'd0);
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
        cmp("post_clear_deadlock", {31'd0, deadlock}, 32'd0);
    endtask

    // Monitor: pops an expected record on each rising report_valid and
    // verifies the record stays stable while the consumer stalls.
    always @(negedge clock) begin
        if (reset) begin
            prev_v = 1'b0;
        end else begin
            if (report_valid && !prev_v) begin
                if (q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_report: got valid=1 expected no report (cycle %0d)", cyc);
                end else begin
                    cur = q.pop_front();
                    cmp("rep_cycle",    cyc, cur.at);
                    cmp("rep_mask",     {28'd0, report_mask}, {28'd0, cur.mask});
                    cmp("rep_idx",      {30'd0, report_mon_idx}, {30'd0, cur.idx});
                    cmp("rep_cycles",   {16'd0, report_cycles}, {16'd0, cur.cycles});
                    cmp("rep_evt",      {24'd0, event_count}, {24'd0, cur.evt});
                    cmp("rep_deadlock", {31'd0, deadlock}, 32'd1);
                end
            end else if (report_valid) begin
                cmp("hold_mask", {28'd0, report_mask}, {28'd0, cur.mask});
                cmp("hold_idx",  {30'd0, report_mon_idx}, {30'd0, cur.idx});
            end
            prev_v = report_valid;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL sim_timeout: got no completion expected $finish");
        $fatal(1, "time limit");
    end

    initial begin
        int start;
        reset = 1'b1; block_in = '0; ap_idle = 1'b0; clear = 1'b0; report_ready = 1'b0;
        tick(3);
        cmp("rst_valid",    {31'd0, report_valid}, 32'd0);
        cmp("rst_deadlock", {31'd0, deadlock}, 32'd0);
        cmp("rst_evt",      {24'd0, event_count}, 32'd0);
        cmp("rst_mask",     {28'd0, report_mask}, 32'd0);
        cmp("rst_cycles",   {16'd0, report_cycles}, 32'd0);
        reset = 1'b0;
        tick(2);

        // Single monitor held; consumer stalls for a while.
        start = cyc; block_in = 4'b0010;
        expect_report(4'b0010, 2'd1, start + 8);
        tick(7);
        cmp("t1_no_early_deadlock", {31'd0, deadlock}, 32'd0);
        tick(1);
        cmp("t1_deadlock", {31'd0, deadlock}, 32'd1);
        tick(4);
        report_ready = 1'b1;
        tick(1);
        report_ready = 1'b0;
        block_in = 4'b0000;
        cmp("t1_latched_deadlock", {31'd0, deadlock}, {31'd0, !AUTO});
        tick(3);
        cmp("t1_latched_hold", {31'd0, deadlock}, {31'd0, !AUTO});
        clear = 1'b1; tick(1); clear = 1'b0;
        cmp("t1_cleared", {31'd0, deadlock}, 32'd0);
        cmp("t1_data_kept", {28'd0, report_mask}, 32'h2);
        tick(2);

        // One unblocked cycle restarts the window.
        start = cyc; block_in = 4'b0001;
        expect_report(4'b0001, 2'd0, start + 16);
        tick(7); block_in = 4'b0000; tick(1); block_in = 4'b0001;
        tick(8);
        handshake_and_clear();
        tick(2);

        // Mask accumulates across a window.
        start = cyc; block_in = 4'b0100;
        expect_report(4'b1100, 2'd2, start + 8);
        tick(4); block_in = 4'b1100; tick(4);
        handshake_and_clear();
        tick(2);

        // Idle design: blocking is never a deadlock.
        ap_idle = 1'b1; block_in = 4'b1111;
        tick(50);
        cmp("idle_valid",    {31'd0, report_valid}, 32'd0);
        cmp("idle_deadlock", {31'd0, deadlock}, 32'd0);
        cmp("idle_evt",      {24'd0, event_count}, exp_evt);
        ap_idle = 1'b0; block_in = 4'b0000;
        tick(2);

        // Clear coincident with the handshake is ignored.
        start = cyc; block_in = 4'b0001;
        expect_report(4'b0001, 2'd0, start + 8);
        tick(8);
        clear = 1'b1; report_ready = 1'b1;
        tick(1);
        clear = 1'b0; report_ready = 1'b0; block_in = 4'b0000;
        cmp("t5_clear_ignored", {31'd0, deadlock}, {31'd0, !AUTO});
        tick(3);
        clear = 1'b1; tick(1); clear = 1'b0;
        cmp("t5_cleared", {31'd0, deadlock}, 32'd0);
        tick(1);
        // Clear mid-window has no effect on the count.
        start = cyc; block_in = 4'b1000;
        expect_report(4'b1000, 2'd3, start + 8);
        tick(3); clear = 1'b1; tick(1); clear = 1'b0; tick(4);
        cmp("t5_evt", {24'd0, event_count}, exp_evt);
        handshake_and_clear();
        tick(2);

        // Reset inside WATCH at stall_cnt=5.
        start = cyc; block_in = 4'b0001;
        tick(5);
        reset = 1'b1; tick(1); reset = 1'b0;
        exp_evt = 0;
        cmp("wrst_valid",    {31'd0, report_valid}, 32'd0);
        cmp("wrst_deadlock", {31'd0, deadlock}, 32'd0);
        cmp("wrst_evt",      {24'd0, event_count}, 32'd0);
        cmp("wrst_idx",      {30'd0, report_mon_idx}, 32'd0);
        expect_report(4'b0001, 2'd0, start + 14);
        tick(8);
        handshake_and_clear();
        tick(2);

        // Continuous blocking with ready held high.
        start = cyc; block_in = 4'b0001; report_ready = 1'b1;
        expect_report(4'b0001, 2'd0, start + 8);
        if (AUTO) begin
            expect_report(4'b0001, 2'd0, start + 17);
            expect_report(4'b0001, 2'd0, start + 26);
        end
        tick(9);
        cmp("cont_deadlock_after_hs", {31'd0, deadlock}, {31'd0, !AUTO});
        tick(18);
        block_in = 4'b0000; report_ready = 1'b0;
        clear = 1'b1; tick(1); clear = 1'b0;
        tick(2);

        // Drive the event counter into saturation.
        report_ready = 1'b1;
        for (int k = 0; k < 256; k++) begin
            start = cyc; block_in = 4'b0001;
            expect_report(4'b0001, 2'd0, start + 8);
            tick(9);
            block_in = 4'b0000;
            clear = 1'b1; tick(1); clear = 1'b0;
        end
        report_ready = 1'b0;
        tick(2);
        cmp("sat_evt", {24'd0, event_count}, 32'd255);
        cmp("queue_drained", q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/photon_deadlock_watchdog.md
Name: photon_deadlock_watchdog

Overview:
- Consumes the `block` outputs of the per-instance HLS deadlock monitors in the photon trigger (one bit per monitor, e.g. photon_factory_U0).
- Qualifies blocking against design idle and a persistence timeout.
- Raises a sticky `deadlock` flag and emits one report record per event over a valid/ready handshake to the control/status (AXI-Lite) layer.

Parameters:
- NUM_MON, 4: number of monitor block inputs (≥1).
- TIMEOUT, 1024: consecutive blocked cycles required to declare deadlock (≥2).
- CNT_W, 16: width of the stall counter and `report_cycles`; must satisfy TIMEOUT < 2^CNT_W.
- IDX_W, $clog2(NUM_MON) (min 1): width of the monitor index.

Ports:
- clock  in  1  system clock.
- reset  in  1  reset, synchronous, active-high.
- block_in  in  NUM_MON  per-monitor block flags, sampled every cycle.
- ap_idle  in  1  top-level HLS idle; while high, blocking is not a deadlock.
- clear  in  1  single-cycle pulse that re-arms after a reported deadlock.
- report_valid  out  1  report record available.
- report_ready  in  1  consumer accepts record.
- report_mon_idx  out  IDX_W  lowest monitor index set in `report_mask`.
- report_mask  out  NUM_MON  OR of `block_in` over the whole stall window.
- report_cycles  out  CNT_W  stall length at report (= TIMEOUT).
- deadlock  out  1  sticky deadlock flag.
- event_count  out  8  saturating count of declared deadlocks.

Behaviour:
- Reset: all outputs and registers are 0; state = IDLE. Reset overrides every other input, including mid-report.
- Define `blk` = |block_in & ~ap_idle.
- IDLE:
  - If `blk`: go to WATCH, stall_cnt <= 1, acc_mask <= block_in.
  - Otherwise remain in IDLE.
- WATCH:
  - If not `blk`: go to IDLE, stall_cnt <= 0, acc_mask <= 0. Any single unblocked cycle or any cycle with ap_idle high restarts the window.
  - Else if stall_cnt == TIMEOUT-1: go to REPORT. Load report_mask <= acc_mask | block_in, report_cycles <= TIMEOUT, report_mon_idx <= lowest set bit of that mask. Set deadlock <= 1. event_count increments, saturating at 255.
  - Else: stall_cnt++, acc_mask |= block_in.
- Latency: if `blk` is first seen in cycle 0 and held, report_valid and deadlock are high from cycle TIMEOUT.
- REPORT:
  - report_valid = 1 and all report_* outputs are stable until the handshake.
  - report_valid && report_ready: go to LATCHED, report_valid <= 0.
  - clear is ignored in REPORT, including when it coincides with report_ready.
  - block_in and ap_idle are ignored.
- LATCHED:
  - deadlock stays 1; report_* fields retain their values; block_in is ignored.
  - clear: go to IDLE, deadlock <= 0, stall_cnt <= 0, acc_mask <= 0. The report_* data registers keep their last value.
  - clear has no effect in IDLE or WATCH.
- Mask change within a window (a different monitor blocks) does not restart the count; bits accumulate in acc_mask.
- report_valid is never asserted outside REPORT and never drops without the handshake.

Optional Feature:
- Macro PHOTON_DEADLOCK_AUTO_REARM_EN.
- Defined:
  - The handshake in REPORT returns directly to IDLE and clears deadlock in the same edge; LATCHED is unreachable; clear is ignored.
  - Continuous blocking therefore yields a new report every TIMEOUT+1 cycles: one IDLE re-entry cycle plus TIMEOUT.
- Undefined: behaviour as above; LATCHED waits for clear.

Decomposition:
- Package photon_deadlock_pkg holds:
  - state enum {IDLE, WATCH, REPORT, LATCHED};
  - EVT_W = 8 constant;
  - packed report record typedef {mon_idx, mask, cycles}.
- One sub-module is natural: photon_lowest_set_idx, a parameterised priority encoder (mask → index plus any-set flag), used for report_mon_idx.

Test Plan (NUM_MON=4, TIMEOUT=8, CNT_W=16; macro undefined unless stated):
- block_in=4'b0010 held from cycle 0, ap_idle=0, report_ready=0 → report_valid=1 and deadlock=1 in cycle 8; mask=0010, idx=1, cycles=8, event_count=1; outputs held while ready low.
- block_in=0001 for 7 cycles, 0000 for 1 cycle, then 0001 again → no report until 8 further blocked cycles; report in cycle 16 relative to start.
- block_in=0100 cycles 0–3, then 1100 cycles 4–7 → mask=1100, idx=2 in cycle 8.
- block_in=1111 with ap_idle=1 for 50 cycles → state stays IDLE, report_valid=0, event_count=0.
- In REPORT, pulse clear together with report_ready → LATCHED, deadlock=1. Later clear → deadlock=0, IDLE; block for another 8 cycles → second report, event_count=2.
- PHOTON_DEADLOCK_AUTO_REARM_EN, block_in=0001 constant, report_ready=1 → report_valid pulses in cycles 8, 17, 26; deadlock low one cycle after each handshake.
- Apply reset in WATCH at stall_cnt=5 → all outputs 0 next cycle; the count restarts from 1 on the next blocked cycle.
